// File: rtl/disp_mux_bank_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display bank.
// Segment patterns are active low, bit order {dp,g,f,e,d,c,b,a}.
package disp_pkg;

   typedef logic [7:0] seg_t;

   localparam seg_t SEG_BLANK = 8'hFF;

   // Hex nibble to active-low segment pattern with the decimal point off.
   function automatic seg_t hex_to_seg(input logic [3:0] hex);
      seg_t seg;
      case (hex)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/disp_mux_bank_if.sv
// Control and pin bundle of disp_mux_bank. blink_mask exists only when
// DISP_BLINK_EN is defined.
interface disp_mux_bank_if #(
   parameter int unsigned N_DIG = 4,
   parameter int unsigned BR_W  = 4
) ();
   import disp_pkg::*;

   logic [N_DIG-1:0] ld;
   seg_t             din;
   logic [BR_W-1:0]  bright;
   logic             blank;
`ifdef DISP_BLINK_EN
   logic [N_DIG-1:0] blink_mask;
`endif
   logic [N_DIG-1:0] an;
   seg_t             sseg;

`ifdef DISP_BLINK_EN
   modport master (output ld, din, bright, blank, blink_mask, input an, sseg);
   modport slave  (input ld, din, bright, blank, blink_mask, output an, sseg);
`else
   modport master (output ld, din, bright, blank, input an, sseg);
   modport slave  (input ld, din, bright, blank, output an, sseg);
`endif

endinterface

// File: rtl/disp_mux_bank_scan_timer.sv
// Slot counter and digit index for the display scan, with one-cycle pulses
// marking the last cycle of each slot and of each full frame.
module disp_scan_timer #(
   parameter int unsigned SCAN_W = 18,
   parameter int unsigned N_DIG  = 4,
   localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [SCAN_W-1:0] cnt,
   output logic [IDX_W-1:0]  idx,
   output logic              slot_wrap,
   output logic              frame_wrap
);

   assign slot_wrap  = (cnt == '1);
   assign frame_wrap = slot_wrap && (idx == IDX_W'(N_DIG - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt + SCAN_W'(1);
         if (slot_wrap) begin
            idx <= frame_wrap ? '0 : idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/disp_mux_bank.sv
// N-digit time-multiplexed 7-segment driver with per-digit pattern bank,
// brightness PWM and blanking. Define DISP_BLINK_EN for per-digit blinking.
module disp_mux_bank
   import disp_pkg::*;
#(
   parameter int unsigned N_DIG   = 4,
   parameter int unsigned SCAN_W  = 18,
   parameter int unsigned BR_W    = 4,
   parameter int unsigned BLINK_W = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   disp_mux_bank_if.slave  bus
);

   localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   if (N_DIG < 2 || N_DIG > 8 || BR_W > SCAN_W || BR_W == 0 || BLINK_W == 0) begin : g_bad_cfg
      $error("disp_mux_bank: unsupported parameter combination");
   end

   logic [SCAN_W-1:0] cnt;
   logic [IDX_W-1:0]  idx;
   logic              slot_wrap;
   logic              frame_wrap;
   logic              on;
   logic              blink_off;
   logic [N_DIG-1:0]  an_sel;
   logic              unused_ok;
   seg_t              d_reg [N_DIG];

   disp_scan_timer #(
      .SCAN_W (SCAN_W),
      .N_DIG  (N_DIG)
   ) u_scan (
      .clk        (clk),
      .reset_n    (reset_n),
      .cnt        (cnt),
      .idx        (idx),
      .slot_wrap  (slot_wrap),
      .frame_wrap (frame_wrap)
   );

`ifdef DISP_BLINK_EN
   logic [BLINK_W-1:0] frame_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (frame_wrap) begin
         frame_cnt <= frame_cnt + BLINK_W'(1);
      end
   end

   // Upper half of every blink period darkens the masked digits.
   assign blink_off = bus.blink_mask[idx] & frame_cnt[BLINK_W-1];
   assign unused_ok = ^{slot_wrap, cnt};
`else
   assign blink_off = 1'b0;
   assign unused_ok = ^{slot_wrap, frame_wrap, cnt};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < N_DIG; i++) begin
            d_reg[i] <= SEG_BLANK;
         end
      end else begin
         for (int unsigned i = 0; i < N_DIG; i++) begin
            if (bus.ld[i]) begin
               d_reg[i] <= bus.din;
            end
         end
      end
   end

   // All-ones brightness bypasses the compare so the digit is lit the whole slot.
   assign on     = (bus.bright == '1) || (cnt[SCAN_W-1 -: BR_W] < bus.bright);
   assign an_sel = ~(N_DIG'(1) << idx);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.an   <= '1;
         bus.sseg <= SEG_BLANK;
      end else begin
         bus.sseg <= d_reg[idx];
         bus.an   <= (on && !bus.blank && !blink_off) ? an_sel : '1;
      end
   end

endmodule
